// File: rtl/cfs_md_pkg.sv
// Shared MD bus helpers: derived field widths and the transfer legality rule.
package cfs_md_pkg;

  function automatic int md_offset_width(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
  endfunction

  function automatic int md_size_width(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  // Widened to 32 bits so offset + size can never wrap.
  function automatic logic md_is_legal(input logic [31:0] offset, input logic [31:0] size,
                                       input logic [31:0] bytes);
    logic [31:0] m;
    m = size - 32'd1;
    return (size != '0) && ((size & m) == '0) && ((offset & m) == '0) && (offset + size <= bytes);
  endfunction

endpackage

// File: rtl/cfs_md_if.sv
// MD transfer bus: master drives the request fields, slave answers ready/err.
interface cfs_md_if #(
  parameter int DATA_WIDTH = 32
);
  import cfs_md_pkg::*;
  localparam int OFFSET_WIDTH = md_offset_width(DATA_WIDTH);
  localparam int SIZE_WIDTH   = md_size_width(DATA_WIDTH);

  logic                    valid;
  logic [DATA_WIDTH-1:0]   data;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [SIZE_WIDTH-1:0]   size;
  logic                    ready;
  logic                    err;

  modport master (output valid, data, offset, size, input  ready, err);
  modport slave  (input  valid, data, offset, size, output ready, err);
endinterface

// File: rtl/cfs_md_sync_fifo.sv
// Generic single-clock FIFO; full/empty derive from the fill level, pointers wrap naturally.
module cfs_md_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] lvl
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // Storage is reset so the head output is never X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      lvl <= lvl + 1'b1;
      else if (!push && pop) lvl <= lvl - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (lvl == LW'(DEPTH));
  assign empty = (lvl == '0);
endmodule

// File: rtl/cfs_md_rx_buffer.sv
// MD slave front end: rejects illegal transfers with err, buffers legal ones and
// replays them on the downstream master port; keeps saturating error counters.
module cfs_md_rx_buffer
  import cfs_md_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  cfs_md_if.slave                         rx,
  cfs_md_if.master                        tx,
  input  logic                            clr_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_lvl,
  output logic [CNT_WIDTH-1:0]            rx_err_cnt,
  output logic [CNT_WIDTH-1:0]            tx_err_cnt
);
  localparam int BYTES        = DATA_WIDTH / 8;
  localparam int OFFSET_WIDTH = md_offset_width(DATA_WIDTH);
  localparam int SIZE_WIDTH   = md_size_width(DATA_WIDTH);
  localparam int LVL_WIDTH    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [SIZE_WIDTH-1:0]   size;
  } md_item_t;

  md_item_t din, head;
  logic     rdy_q, rdy_d;
  logic     legal, acc, push, pop, full, empty, full_nxt;

  assign legal = md_is_legal(32'(rx.offset), 32'(rx.size), 32'(BYTES));
  assign acc   = rx.valid & rdy_q;
  assign push  = acc & legal;
  assign pop   = ~empty & tx.ready;
  assign din   = '{data: rx.data, offset: rx.offset, size: rx.size};

  assign rx.ready  = rdy_q;
  assign rx.err    = acc & ~legal;
  assign tx.valid  = ~empty;
  assign tx.data   = head.data;
  assign tx.offset = head.offset;
  assign tx.size   = head.size;

  // Full after this cycle's push/pop; a push while full cannot happen.
  assign full_nxt = (full & ~pop) |
                    ((fifo_lvl == LVL_WIDTH'(FIFO_DEPTH - 1)) & push & ~pop);

  // Illegal requests need no space, so they get a ready slot even when full;
  // every accept is followed by one idle cycle.
  always_comb begin
    rdy_d = ~full_nxt;
    if (rx.valid && !legal && !rdy_q) rdy_d = 1'b1;
    if (acc) rdy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= rdy_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_err_cnt <= '0;
      tx_err_cnt <= '0;
    end else if (clr_cnt) begin
      rx_err_cnt <= '0;
      tx_err_cnt <= '0;
    end else begin
      if (rx.err && !(&rx_err_cnt))         rx_err_cnt <= rx_err_cnt + 1'b1;
      if (pop && tx.err && !(&tx_err_cnt)) tx_err_cnt <= tx_err_cnt + 1'b1;
    end
  end

  cfs_md_sync_fifo #(
    .WIDTH ($bits(md_item_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .lvl     (fifo_lvl)
  );
endmodule

// File: tb/tb_cfs_md_rx_buffer.sv
// Directed bench for cfs_md_rx_buffer; a second instance with 2-bit counters
// runs in lockstep on the same stimulus to exercise counter saturation.
module tb_cfs_md_rx_buffer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [3:0] fifo_lvl, fifo_lvl2;
  logic [7:0] rx_err_cnt, tx_err_cnt;
  logic [1:0] rx_err_cnt2, tx_err_cnt2;
  int         nchk = 0;
  int         npass = 0;

  cfs_md_if #(.DATA_WIDTH(32)) rx_if ();
  cfs_md_if #(.DATA_WIDTH(32)) tx_if ();
  cfs_md_if #(.DATA_WIDTH(32)) rx2_if ();
  cfs_md_if #(.DATA_WIDTH(32)) tx2_if ();

  assign rx2_if.valid  = rx_if.valid;
  assign rx2_if.data   = rx_if.data;
  assign rx2_if.offset = rx_if.offset;
  assign rx2_if.size   = rx_if.size;
  assign tx2_if.ready  = tx_if.ready;
  assign tx2_if.err    = tx_if.err;

  always #5 clk = ~clk;

  cfs_md_rx_buffer #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx_if.slave), .tx(tx_if.master), .clr_cnt(clr_cnt),
    .fifo_lvl(fifo_lvl), .rx_err_cnt(rx_err_cnt), .tx_err_cnt(tx_err_cnt));

  cfs_md_rx_buffer #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .rx(rx2_if.slave), .tx(tx2_if.master), .clr_cnt(clr_cnt),
    .fifo_lvl(fifo_lvl2), .rx_err_cnt(rx_err_cnt2), .tx_err_cnt(tx_err_cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted (bounded), return rx_err seen on the accept edge.
  task automatic send(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s,
                      input logic clr, output logic err);
    int n;
    n = 0;
    rx_if.valid = 1'b1; rx_if.data = d; rx_if.offset = o; rx_if.size = s; clr_cnt = clr;
    #1;
    while (rx_if.ready !== 1'b1 && n < 50) begin tick(); n++; end
    nchk++; if (rx_if.ready !== 1'b1) $display("FAIL send_timeout rx_ready got %b exp 1", rx_if.ready); else npass++;
    err = rx_if.err;
    tick();
    rx_if.valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    nchk++; if (rx_if.ready !== 1'b0) $display("FAIL rst_rx_ready got %b exp 0", rx_if.ready); else npass++;
    nchk++; if (rx_if.err !== 1'b0) $display("FAIL rst_rx_err got %b exp 0", rx_if.err); else npass++;
    nchk++; if (tx_if.valid !== 1'b0) $display("FAIL rst_tx_valid got %b exp 0", tx_if.valid); else npass++;
    nchk++; if ({tx_if.data, tx_if.offset, tx_if.size} !== 37'd0)
      $display("FAIL rst_tx_fields got %h exp 0", {tx_if.data, tx_if.offset, tx_if.size}); else npass++;
    nchk++; if (fifo_lvl !== 4'd0) $display("FAIL rst_lvl got %0d exp 0", fifo_lvl); else npass++;
    nchk++; if ({rx_err_cnt, tx_err_cnt} !== 16'd0)
      $display("FAIL rst_cnt got %h exp 0", {rx_err_cnt, tx_err_cnt}); else npass++;
    @(negedge clk); reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_legal();
    logic e;
    nchk++; if (tx_if.valid !== 1'b0) $display("FAIL legal_pre_tx_valid got %b exp 0", tx_if.valid); else npass++;
    send(32'hAABBCCDD, 2'd0, 3'd4, 1'b0, e);
    nchk++; if (e !== 1'b0) $display("FAIL legal_rx_err got %b exp 0", e); else npass++;
    nchk++; if (fifo_lvl !== 4'd1) $display("FAIL legal_lvl got %0d exp 1", fifo_lvl); else npass++;
    nchk++; if (tx_if.valid !== 1'b1) $display("FAIL legal_tx_valid got %b exp 1", tx_if.valid); else npass++;
    nchk++; if (tx_if.data !== 32'hAABBCCDD || tx_if.offset !== 2'd0 || tx_if.size !== 3'd4)
      $display("FAIL legal_tx_fields got %h/%0d/%0d exp aabbccdd/0/4", tx_if.data, tx_if.offset, tx_if.size); else npass++;
    tx_if.ready = 1'b1;
    tick();
    tx_if.ready = 1'b0;
    nchk++; if (fifo_lvl !== 4'd0) $display("FAIL legal_pop_lvl got %0d exp 0", fifo_lvl); else npass++;
    nchk++; if (tx_if.valid !== 1'b0) $display("FAIL legal_pop_tx_valid got %b exp 0", tx_if.valid); else npass++;
  endtask

  task automatic test_illegal();
    logic       e;
    logic [1:0] offs [4] = '{2'd1, 2'd3, 2'd0, 2'd0};
    logic [2:0] sizes[4] = '{3'd2, 3'd2, 3'd0, 3'd3};
    for (int i = 0; i < 4; i++) begin
      send(32'h5A5A0000 + 32'(i), offs[i], sizes[i], 1'b0, e);
      nchk++; if (e !== 1'b1) $display("FAIL illegal%0d_rx_err got %b exp 1", i, e); else npass++;
      nchk++; if (fifo_lvl !== 4'd0) $display("FAIL illegal%0d_lvl got %0d exp 0", i, fifo_lvl); else npass++;
    end
    nchk++; if (rx_if.err !== 1'b0) $display("FAIL illegal_idle_err got %b exp 0", rx_if.err); else npass++;
    nchk++; if (rx_err_cnt !== 8'd4) $display("FAIL illegal_cnt got %0d exp 4", rx_err_cnt); else npass++;
    nchk++; if (rx_err_cnt2 !== 2'd3) $display("FAIL illegal_cnt_sat got %0d exp 3", rx_err_cnt2); else npass++;
  endtask

  task automatic test_fill();
    logic e;
    tx_if.ready = 1'b0;
    tx_if.err   = 1'b1;  // no pop, so this must be ignored
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i), 2'(i), 3'd1, 1'b0, e);
    nchk++; if (fifo_lvl !== 4'd8) $display("FAIL fill_lvl got %0d exp 8", fifo_lvl); else npass++;
    tick();
    nchk++; if (rx_if.ready !== 1'b0) $display("FAIL fill_full_ready got %b exp 0", rx_if.ready); else npass++;
    rx_if.valid = 1'b1; rx_if.data = 32'h1008; rx_if.offset = 2'd0; rx_if.size = 3'd4;
    repeat (3) tick();
    nchk++; if (rx_if.ready !== 1'b0 || fifo_lvl !== 4'd8)
      $display("FAIL fill_wait got ready=%b lvl=%0d exp 0/8", rx_if.ready, fifo_lvl); else npass++;
    send(32'hDEAD0000, 2'd1, 3'd2, 1'b0, e);
    nchk++; if (e !== 1'b1) $display("FAIL fill_illegal_err got %b exp 1", e); else npass++;
    nchk++; if (fifo_lvl !== 4'd8) $display("FAIL fill_illegal_lvl got %0d exp 8", fifo_lvl); else npass++;
    nchk++; if (rx_err_cnt !== 8'd5) $display("FAIL fill_rx_cnt got %0d exp 5", rx_err_cnt); else npass++;
    tick();
    nchk++; if (rx_if.ready !== 1'b0) $display("FAIL fill_ready_after_illegal got %b exp 0", rx_if.ready); else npass++;
    nchk++; if (tx_err_cnt !== 8'd0) $display("FAIL fill_tx_err_ignored got %0d exp 0", tx_err_cnt); else npass++;
    nchk++; if (tx_if.data !== 32'h1000) $display("FAIL fill_head got %h exp 1000", tx_if.data); else npass++;
    tx_if.ready = 1'b1;
    tick();
    tx_if.ready = 1'b0; tx_if.err = 1'b0;
    nchk++; if (rx_if.ready !== 1'b1) $display("FAIL fill_pop_ready got %b exp 1", rx_if.ready); else npass++;
    nchk++; if (fifo_lvl !== 4'd7) $display("FAIL fill_pop_lvl got %0d exp 7", fifo_lvl); else npass++;
    nchk++; if (tx_err_cnt !== 8'd1) $display("FAIL fill_tx_err_cnt got %0d exp 1", tx_err_cnt); else npass++;
    send(32'h1008, 2'd0, 3'd4, 1'b0, e);
    nchk++; if (e !== 1'b0 || fifo_lvl !== 4'd8)
      $display("FAIL fill_ninth got err=%b lvl=%0d exp 0/8", e, fifo_lvl); else npass++;
    tx_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      nchk++; if (tx_if.data !== 32'h1000 + 32'(i) || tx_if.offset !== ((i < 8) ? 2'(i) : 2'd0))
        $display("FAIL fill_drain%0d got %h/%0d exp %h/%0d", i, tx_if.data, tx_if.offset,
                 32'h1000 + 32'(i), (i < 8) ? i % 4 : 0); else npass++;
      tick();
    end
    tx_if.ready = 1'b0;
    nchk++; if (tx_if.valid !== 1'b0 || fifo_lvl !== 4'd0)
      $display("FAIL fill_empty got valid=%b lvl=%0d exp 0/0", tx_if.valid, fifo_lvl); else npass++;
  endtask

  task automatic test_concurrent();
    logic        e, acc;
    logic [31:0] q[$];
    logic [31:0] nxt;
    int          nacc;
    nacc = 0;
    tx_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'h2000 + 32'(i), 2'd0, 3'd4, 1'b0, e);
      q.push_back(32'h2000 + 32'(i));
    end
    nxt = 32'h2003;
    rx_if.valid = 1'b1; rx_if.data = nxt; rx_if.offset = 2'd0; rx_if.size = 3'd4;
    for (int c = 0; c < 20; c++) begin
      acc = (rx_if.ready === 1'b1);
      tx_if.ready = acc;
      #1;
      if (acc) begin
        nchk++; if (tx_if.data !== q[0]) $display("FAIL conc_order c%0d got %h exp %h", c, tx_if.data, q[0]); else npass++;
        void'(q.pop_front());
        q.push_back(nxt);
        nacc++;
      end
      tick();
      nchk++; if (fifo_lvl !== 4'd3) $display("FAIL conc_lvl c%0d got %0d exp 3", c, fifo_lvl); else npass++;
      if (acc) begin nxt = nxt + 32'd1; rx_if.data = nxt; end
    end
    nchk++; if (nacc !== 10) $display("FAIL conc_accepts got %0d exp 10", nacc); else npass++;
    rx_if.valid = 1'b0;
    tx_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nchk++; if (tx_if.data !== q[0]) $display("FAIL conc_drain%0d got %h exp %h", i, tx_if.data, q[0]); else npass++;
      void'(q.pop_front());
      tick();
    end
    tx_if.ready = 1'b0;
    nchk++; if (tx_if.valid !== 1'b0) $display("FAIL conc_empty got %b exp 0", tx_if.valid); else npass++;
  endtask

  task automatic test_reset_mid();
    logic e;
    for (int i = 0; i < 5; i++) send(32'h3000 + 32'(i), 2'd0, 3'd4, 1'b0, e);
    tick();
    nchk++; if (fifo_lvl !== 4'd5 || tx_if.valid !== 1'b1 || rx_if.ready !== 1'b1)
      $display("FAIL mid_pre got lvl=%0d valid=%b ready=%b exp 5/1/1", fifo_lvl, tx_if.valid, rx_if.ready); else npass++;
    nchk++; if (rx_err_cnt !== 8'd5 || tx_err_cnt !== 8'd1)
      $display("FAIL mid_pre_cnt got %0d/%0d exp 5/1", rx_err_cnt, tx_err_cnt); else npass++;
    #3 reset_n = 1'b0;
    #1;
    nchk++; if (tx_if.valid !== 1'b0) $display("FAIL mid_tx_valid got %b exp 0", tx_if.valid); else npass++;
    nchk++; if (rx_if.ready !== 1'b0) $display("FAIL mid_rx_ready got %b exp 0", rx_if.ready); else npass++;
    nchk++; if (fifo_lvl !== 4'd0) $display("FAIL mid_lvl got %0d exp 0", fifo_lvl); else npass++;
    nchk++; if (rx_err_cnt !== 8'd0 || tx_err_cnt !== 8'd0)
      $display("FAIL mid_cnt got %0d/%0d exp 0/0", rx_err_cnt, tx_err_cnt); else npass++;
    nchk++; if (tx_if.data !== 32'd0) $display("FAIL mid_tx_data got %h exp 0", tx_if.data); else npass++;
    @(negedge clk); reset_n = 1'b1;
    tick();
  endtask

  task automatic test_counters();
    logic e;
    for (int i = 0; i < 5; i++) send(32'h4000 + 32'(i), 2'd0, 3'd4, 1'b0, e);
    tx_if.ready = 1'b1; tx_if.err = 1'b1;
    repeat (5) tick();
    tx_if.ready = 1'b0; tx_if.err = 1'b0;
    nchk++; if (fifo_lvl !== 4'd0) $display("FAIL cnt_lvl got %0d exp 0", fifo_lvl); else npass++;
    nchk++; if (tx_err_cnt !== 8'd5) $display("FAIL cnt_tx got %0d exp 5", tx_err_cnt); else npass++;
    nchk++; if (tx_err_cnt2 !== 2'd3) $display("FAIL cnt_tx_sat got %0d exp 3", tx_err_cnt2); else npass++;
    send(32'h0, 2'd1, 3'd2, 1'b0, e);
    send(32'h0, 2'd0, 3'd3, 1'b0, e);
    nchk++; if (rx_err_cnt !== 8'd2 || rx_err_cnt2 !== 2'd2)
      $display("FAIL cnt_rx got %0d/%0d exp 2/2", rx_err_cnt, rx_err_cnt2); else npass++;
    send(32'h0, 2'd3, 3'd2, 1'b1, e);
    nchk++; if (e !== 1'b1) $display("FAIL cnt_clr_err got %b exp 1", e); else npass++;
    nchk++; if (rx_err_cnt !== 8'd0 || rx_err_cnt2 !== 2'd0)
      $display("FAIL cnt_clr_rx got %0d/%0d exp 0/0", rx_err_cnt, rx_err_cnt2); else npass++;
    nchk++; if (tx_err_cnt !== 8'd0 || tx_err_cnt2 !== 2'd0)
      $display("FAIL cnt_clr_tx got %0d/%0d exp 0/0", tx_err_cnt, tx_err_cnt2); else npass++;
  endtask

  initial begin
    rx_if.valid = 1'b0; rx_if.data = '0; rx_if.offset = '0; rx_if.size = '0;
    tx_if.ready = 1'b0; tx_if.err = 1'b0;
    test_reset();
    test_legal();
    test_illegal();
    test_fill();
    test_concurrent();
    test_reset_mid();
    test_counters();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
